demux_scan_ctrl: RTL and testbench

Sequencer that drives the 1-to-8 demultiplexer stage: it latches one data bit and steers it through the demux select lines, either to a single addressed channel or round-robin across all eight. It holds each channel for a programmable dwell time and inserts a blanking cycle between channels so selects never change while data is asserted. It sits directly upstream of `demux_1to8`; its `I`, `S1`, `S2`, `S3` outputs connect one-to-one to that block's inputs.

---
 rtl/demux_scan_pkg.sv | 17 +
 rtl/demux_1to8.sv | 18 +
 rtl/demux_dwell_timer.sv | 39 +++
 rtl/demux_scan_ctrl.sv | 129 ++++++++++++
 tb/tb_demux_scan_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/demux_scan_pkg.sv
// Shared types and constants for the demux scan sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package demux_scan_pkg;

  localparam int CHAN_W   = 3;
  localparam int NUM_CHAN = 8;
  localparam int CNT_W    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/demux_1to8.sv
// 1-to-8 demultiplexer: routes I to output O[{S3,S2,S1}], all other outputs low.
// Latency: purely combinational.
// Backpressure: none.
module demux_1to8 (
  input  logic       I,
  input  logic       S1,
  input  logic       S2,
  input  logic       S3,
  output logic [7:0] O
);

  // Steer the data bit onto the selected line.
  always_comb begin
    O = 8'd0;
    O[{S3, S2, S1}] = I;
  end

endmodule

// File: rtl/demux_dwell_timer.sv
// Loadable down-counter that times how long one channel is driven.
// Latency: load/decrement take effect on the next rising edge; zero flag is combinational from the count.
// Backpressure: none; saturates at zero when decremented with nothing left.
module demux_dwell_timer
  import demux_scan_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Load wins over decrement; never wrap below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/demux_scan_ctrl.sv
// Sequences one data bit onto a 1-to-8 demux, single channel or round-robin scan, with a blanking gap between channels.
// Latency: first channel driven the cycle after start is sampled; all outputs registered.
// Backpressure: start is only accepted in IDLE and is dropped (not queued) otherwise; abort ends an operation next edge.
module demux_scan_ctrl
  import demux_scan_pkg::*;
#(
  parameter int unsigned DWELL = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [CHAN_W-1:0] addr,
  input  logic              data_in,
  input  logic              abort,
  output logic              I,
  output logic              S1,
  output logic              S2,
  output logic              S3,
  output logic [CHAN_W-1:0] chan,
  output logic              busy,
  output logic              done
);

  localparam logic [CNT_W-1:0]  DWELL_M1   = CNT_W'(DWELL - 1);
  localparam logic [CHAN_W-1:0] LAST_VISIT = CHAN_W'(NUM_CHAN - 1);

  state_e            state_q;
  logic              mode_q;
  logic              data_q;
  logic [CHAN_W-1:0] chan_q;
  logic [CHAN_W-1:0] visit_q;
  logic              i_q;
  logic              busy_q;
  logic              done_q;

  logic tmr_load;
  logic tmr_dec;
  logic tmr_zero;

  // Reload the dwell count when an operation launches and on every gap cycle.
  assign tmr_load = ((state_q == IDLE) && start) || ((state_q == GAP) && !abort);
  assign tmr_dec  = (state_q == DRIVE);

  demux_dwell_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (DWELL_M1),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  // Sequencer FSM with registered outputs. The channel only advances on the
  // edge into GAP, where I is forced low, so selects never move under data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      data_q  <= 1'b0;
      chan_q  <= '0;
      visit_q <= '0;
      i_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      i_q    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            mode_q  <= mode;
            data_q  <= data_in;
            chan_q  <= addr;
            visit_q <= '0;
            i_q     <= data_in;
            busy_q  <= 1'b1;
            state_q <= DRIVE;
          end
        end
        DRIVE: begin
          if (abort) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (tmr_zero) begin
            if (mode_q || (visit_q == LAST_VISIT)) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              chan_q  <= chan_q + 1'b1;
              visit_q <= visit_q + 1'b1;
              busy_q  <= 1'b1;
              state_q <= GAP;
            end
          end else begin
            i_q    <= data_q;
            busy_q <= 1'b1;
          end
        end
        GAP: begin
          if (abort) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            i_q     <= data_q;
            busy_q  <= 1'b1;
            state_q <= DRIVE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign I    = i_q;
  assign S1   = chan_q[0];
  assign S2   = chan_q[1];
  assign S3   = chan_q[2];
  assign chan = chan_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_demux_scan_ctrl.sv
// Bench for demux_scan_ctrl feeding demux_1to8, two instances (DWELL=4 and DWELL=2).
// Latency: n/a.
// Backpressure: n/a.
module tb_demux_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start4;
  logic       start2;
  logic       mode;
  logic [2:0] addr;
  logic       data_in;
  logic       abort;

  logic       i4, s1_4, s2_4, s3_4, busy4, done4;
  logic [2:0] chan4;
  logic [7:0] dmx4;
  logic       i2, s1_2, s2_2, s3_2, busy2, done2;
  logic [2:0] chan2;

  int n_total;
  int n_pass;

  demux_scan_ctrl #(.DWELL(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .mode(mode), .addr(addr),
    .data_in(data_in), .abort(abort), .I(i4), .S1(s1_4), .S2(s2_4), .S3(s3_4),
    .chan(chan4), .busy(busy4), .done(done4)
  );

  demux_1to8 u_dmx4 (
    .I(i4), .S1(s1_4), .S2(s2_4), .S3(s3_4), .O(dmx4)
  );

  demux_scan_ctrl #(.DWELL(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .mode(mode), .addr(addr),
    .data_in(data_in), .abort(abort), .I(i2), .S1(s1_2), .S2(s2_2), .S3(s3_2),
    .chan(chan2), .busy(busy2), .done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {I, S3,S2,S1, chan, busy, done}
  function automatic logic [8:0] obs4();
    return {i4, s3_4, s2_4, s1_4, chan4, busy4, done4};
  endfunction

  function automatic logic [8:0] obs2();
    return {i2, s3_2, s2_2, s1_2, chan2, busy2, done2};
  endfunction

  function automatic logic [8:0] expw(input logic ei, input logic [2:0] ch,
                                      input logic eb, input logic ed);
    return {ei, ch, ch, eb, ed};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       st;
    logic       md;
    logic [2:0] ad;
    logic       dt;
    logic       ab;
    logic       ei;
    logic [2:0] ech;
    logic       eb;
    logic       ed;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic st, input logic md, input logic [2:0] ad, input logic dt,
                     input logic ab, input logic ei, input logic [2:0] ech,
                     input logic eb, input logic ed);
    vec_t v;
    v.st = st; v.md = md; v.ad = ad; v.dt = dt; v.ab = ab;
    v.ei = ei; v.ech = ech; v.eb = eb; v.ed = ed;
    vq.push_back(v);
  endtask

  initial begin
    logic [7:0] edmx;
    logic       e_i, e_b, e_d, prev_b;
    logic [2:0] e_ch, prev_ch;
    int         k, r;

    n_total = 0;
    n_pass  = 0;
    rst_n   = 1'b0;
    start4  = 1'b0;
    start2  = 1'b0;
    mode    = 1'b0;
    addr    = 3'd0;
    data_in = 1'b0;
    abort   = 1'b0;

    // ---------------- reset ----------------
    step();
    step();
    check("reset_dut4", 32'(obs4()), 32'(0));
    check("reset_dut2", 32'(obs2()), 32'(0));
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      check($sformatf("idle_quiet4[%0d]", c), 32'(obs4()), 32'(0));
      check($sformatf("idle_quiet2[%0d]", c), 32'(obs2()), 32'(0));
    end

    // ---------------- table-driven single-mode vectors (DWELL=4) ----------------
    // Row inputs are applied during cycle n; expectation is for cycle n+1.
    // Op A: addr 6, data 1; start pulse during DRIVE must be ignored.
    add(1,1,3'd6,1,0, 1,3'd6,1,0);
    add(1,0,3'd2,0,0, 1,3'd6,1,0);
    add(0,0,3'd0,0,0, 1,3'd6,1,0);
    add(0,0,3'd0,0,0, 1,3'd6,1,0);
    add(0,0,3'd0,0,0, 0,3'd6,0,1);
    add(0,0,3'd0,0,0, 0,3'd6,0,0);
    add(0,0,3'd0,0,1, 0,3'd6,0,0);
    // Op B: addr 1, data 0 runs full length with I low.
    add(1,1,3'd1,0,0, 0,3'd1,1,0);
    add(0,0,3'd0,0,0, 0,3'd1,1,0);
    add(0,0,3'd0,0,0, 0,3'd1,1,0);
    add(0,0,3'd0,0,0, 0,3'd1,1,0);
    add(0,0,3'd0,0,0, 0,3'd1,0,1);
    add(0,0,3'd0,0,0, 0,3'd1,0,0);
    // Op C: addr 0, data 1, abort during second DRIVE cycle.
    add(1,1,3'd0,1,0, 1,3'd0,1,0);
    add(0,0,3'd0,0,0, 1,3'd0,1,0);
    add(0,0,3'd0,0,1, 0,3'd0,0,1);
    add(0,0,3'd0,0,0, 0,3'd0,0,0);

    foreach (vq[i]) begin
      start4  = vq[i].st;
      mode    = vq[i].md;
      addr    = vq[i].ad;
      data_in = vq[i].dt;
      abort   = vq[i].ab;
      step();
      check($sformatf("vec[%0d]", i), 32'(obs4()),
            32'(expw(vq[i].ei, vq[i].ech, vq[i].eb, vq[i].ed)));
      edmx = 8'd0;
      if (vq[i].ei) edmx = 8'd1 << vq[i].ech;
      check($sformatf("vec_demux[%0d]", i), 32'(dmx4), 32'(edmx));
    end
    start4 = 1'b0; mode = 1'b0; addr = 3'd0; data_in = 1'b0; abort = 1'b0;
    step();

    // ---------------- scan, DWELL=2, addr 5 ----------------
    mode = 1'b0; addr = 3'd5; data_in = 1'b1; start2 = 1'b1;
    step();
    start2 = 1'b0; addr = 3'd0; data_in = 1'b0;
    prev_b  = 1'b0;
    prev_ch = 3'd0;
    for (int c = 1; c <= 26; c++) begin
      k = (c - 1) / 3;
      r = (c - 1) % 3;
      if (c < 24) begin
        e_i  = (r < 2);
        e_ch = (r < 2) ? 3'((5 + k) % 8) : 3'((6 + k) % 8);
        e_b  = 1'b1;
        e_d  = 1'b0;
      end else begin
        e_i  = 1'b0;
        e_ch = 3'd4;
        e_b  = 1'b0;
        e_d  = (c == 24);
      end
      check($sformatf("scan[c%0d]", c), 32'(obs2()), 32'(expw(e_i, e_ch, e_b, e_d)));
      if (c >= 2) begin
        check($sformatf("scan_glitch[c%0d]", c),
              32'(i2 && prev_b && (chan2 != prev_ch)), 32'(0));
      end
      prev_b  = busy2;
      prev_ch = chan2;
      // Start pulses in GAP and in DONE must both be dropped.
      start2 = (c == 3) || (c == 24);
      mode   = (c == 3);
      step();
    end
    start2 = 1'b0; mode = 1'b0;

    // ---------------- abort in scan, DWELL=4 ----------------
    mode = 1'b0; addr = 3'd0; data_in = 1'b1; start4 = 1'b1;
    step();
    start4 = 1'b0; data_in = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c <= 4)       check($sformatf("abort[c%0d]", c), 32'(obs4()), 32'(expw(1, 3'd0, 1, 0)));
      else if (c == 5)  check("abort[c5]", 32'(obs4()), 32'(expw(0, 3'd1, 1, 0)));
      else if (c == 6)  check("abort[c6]", 32'(obs4()), 32'(expw(1, 3'd1, 1, 0)));
      else if (c == 7)  check("abort[c7]", 32'(obs4()), 32'(expw(0, 3'd1, 0, 1)));
      else              check("abort[c8]", 32'(obs4()), 32'(expw(0, 3'd1, 0, 0)));
      abort = (c == 6);
      step();
    end
    abort = 1'b0;

    // ---------------- back-to-back with start held ----------------
    mode = 1'b1; addr = 3'd3; data_in = 1'b1; start4 = 1'b1;
    step();
    for (int c = 1; c <= 7; c++) begin
      if (c <= 4)      check($sformatf("b2b[c%0d]", c), 32'(obs4()), 32'(expw(1, 3'd3, 1, 0)));
      else if (c == 5) check("b2b[c5]", 32'(obs4()), 32'(expw(0, 3'd3, 0, 1)));
      else if (c == 6) check("b2b[c6]", 32'(obs4()), 32'(expw(0, 3'd3, 0, 0)));
      else             check("b2b[c7]", 32'(obs4()), 32'(expw(1, 3'd3, 1, 0)));
      if (c == 7) start4 = 1'b0;
      step();
    end
    // Now in cycle 8; second op drives cycles 7..10, done in 11.
    step(); step(); step();
    check("b2b[c11]", 32'(obs4()), 32'(expw(0, 3'd3, 0, 1)));
    step();

    // ---------------- async reset mid-scan ----------------
    mode = 1'b0; addr = 3'd2; data_in = 1'b1; start2 = 1'b1;
    step();
    start2 = 1'b0;
    step();
    step();
    check("pre_rst_scan", 32'(obs2()), 32'(expw(0, 3'd3, 1, 0)));
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_dut2", 32'(obs2()), 32'(0));
    check("async_rst_dut4", 32'(obs4()), 32'(0));
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("post_rst_idle[%0d]", c), 32'(obs2()), 32'(0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
